// File: rtl/sap_ctrl_pkg.sv
// Shared constants for the SAP-1 microcoded sequencer: control word bit
// positions, opcodes, start addresses, T-state encoding and control ROM contents.
package sap_ctrl_pkg;

  localparam int CW_CP   = 11;
  localparam int CW_EP   = 10;
  localparam int CW_LM_N = 9;
  localparam int CW_CE_N = 8;
  localparam int CW_LI_N = 7;
  localparam int CW_EI_N = 6;
  localparam int CW_LA_N = 5;
  localparam int CW_EA   = 4;
  localparam int CW_SU   = 3;
  localparam int CW_EU   = 2;
  localparam int CW_LB_N = 1;
  localparam int CW_LO_N = 0;

  localparam logic [11:0] CW_NOP = 12'h3E3;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [3:0] SA_LDA = 4'd3;
  localparam logic [3:0] SA_ADD = 4'd6;
  localparam logic [3:0] SA_SUB = 4'd9;
  localparam logic [3:0] SA_OUT = 4'd12;
  localparam logic [3:0] SA_NOP = 4'd15;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_t;

  // Each entry is {end, cw}; end marks the last word of an execute sequence.
  localparam logic [12:0] CROM_INIT [16] = '{
    13'h05E3, 13'h0BE3, 13'h0263,
    13'h01A3, 13'h12C3, 13'h03E3,
    13'h01A3, 13'h02E1, 13'h13C7,
    13'h01A3, 13'h02E1, 13'h13CF,
    13'h13F2, 13'h03E3, 13'h03E3,
    13'h13E3
  };

  function automatic logic [3:0] start_addr(input logic [3:0] op);
    case (op)
      OP_LDA:  return SA_LDA;
      OP_ADD:  return SA_ADD;
      OP_SUB:  return SA_SUB;
      OP_OUT:  return SA_OUT;
      default: return SA_NOP;
    endcase
  endfunction

endpackage

// File: rtl/microprogrammed_sequencer_if.sv
// Opcode in, control word / halt / debug state out between the datapath and
// the sequencer. slave = sequencer side, master = datapath side.
interface microprogrammed_sequencer_if #(parameter int UPC_W = 4);
  logic [3:0]       op_code;
  logic             cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n;
  logic             hlt_n;
  logic [5:0]       state;
  logic [UPC_W-1:0] upc;

  modport slave (
    input  op_code,
    output cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n,
    output hlt_n, state, upc
  );

  modport master (
    output op_code,
    input  cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n,
    input  hlt_n, state, upc
  );
endinterface

// File: rtl/microprogrammed_sequencer_control_rom.sv
// 16 x 13 combinational microcode ROM, {end, cw} addressed by the uPC.
module control_rom
  import sap_ctrl_pkg::*;
(
  input  logic [3:0]  addr_i,
  output logic [12:0] word_o
);
  assign word_o = CROM_INIT[addr_i];
endmodule

// File: rtl/microprogrammed_sequencer.sv
// Microcoded SAP-1 controller: uPC, T-state ring and halt flag advance on the falling edge.
// Build option EARLY_END_EN lets a microword's end bit cut the instruction short.
module microprogrammed_sequencer
  import sap_ctrl_pkg::*;
#(
  parameter int CW_W  = 12,
  parameter int UPC_W = 4
) (
  input  logic                        clk,
  input  logic                        clr,
  microprogrammed_sequencer_if.slave  bus
);

  logic [UPC_W-1:0] upc_q;
  tstate_t          t_q;
  logic             halt_q;
  logic [12:0]      rom_word;
  logic [CW_W-1:0]  cw;
  logic             hlt_n;
  logic             early_end;

  control_rom u_rom (
    .addr_i (upc_q),
    .word_o (rom_word)
  );

`ifdef EARLY_END_EN
  assign early_end = rom_word[12];
`else
  logic unused_end;
  assign unused_end = rom_word[12];
  assign early_end  = 1'b0;
`endif

  always_ff @(negedge clk) begin
    if (clr) begin
      upc_q  <= '0;
      t_q    <= T1;
      halt_q <= 1'b0;
    end else if (!halt_q) begin
      if (t_q == T3) begin
        // HLT parks at T4 with the fetch address still in the uPC.
        if (bus.op_code == OP_HLT) halt_q <= 1'b1;
        else                       upc_q  <= start_addr(bus.op_code);
        t_q <= T4;
      end else if (t_q == T6 || early_end) begin
        upc_q <= '0;
        t_q   <= T1;
      end else begin
        t_q <= tstate_t'({t_q[4:0], 1'b0});
        if (upc_q != '1) upc_q <= upc_q + 1'b1;
      end
    end
  end

  always_comb begin
    cw    = rom_word[CW_W-1:0];
    hlt_n = 1'b1;
    if (clr) begin
      cw = CW_NOP;
    end else if (halt_q) begin
      cw    = CW_NOP;
      hlt_n = 1'b0;
    end
  end

  assign bus.cp    = cw[CW_CP];
  assign bus.ep    = cw[CW_EP];
  assign bus.lm_n  = cw[CW_LM_N];
  assign bus.ce_n  = cw[CW_CE_N];
  assign bus.li_n  = cw[CW_LI_N];
  assign bus.ei_n  = cw[CW_EI_N];
  assign bus.la_n  = cw[CW_LA_N];
  assign bus.ea    = cw[CW_EA];
  assign bus.su    = cw[CW_SU];
  assign bus.eu    = cw[CW_EU];
  assign bus.lb_n  = cw[CW_LB_N];
  assign bus.lo_n  = cw[CW_LO_N];
  assign bus.hlt_n = hlt_n;
  assign bus.state = t_q;
  assign bus.upc   = upc_q;

endmodule
